// File: rtl/mem_arbiter.sv
// Two-master, one-slave AXI-lite arbiter sharing the memory port between
// the instruction fetch unit (m0, read-only) and the load/store unit (m1).
// A single transaction is in flight at a time; the owner stays locked from
// address handshake until the response handshake completes.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int STRB_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_arvalid,
    input  logic [ADDR_W-1:0] m0_araddr,
    output logic              m0_arready,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    input  logic              m0_rready,
    input  logic              m1_arvalid,
    input  logic [ADDR_W-1:0] m1_araddr,
    output logic              m1_arready,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    input  logic              m1_rready,
    input  logic              m1_awvalid,
    input  logic [ADDR_W-1:0] m1_awaddr,
    output logic              m1_awready,
    input  logic              m1_wvalid,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [STRB_W-1:0] m1_wstrb,
    output logic              m1_wready,
    output logic              m1_bvalid,
    output logic [1:0]        m1_bresp,
    input  logic              m1_bready,
    output logic              s_arvalid,
    output logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arready,
    input  logic              s_rvalid,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    output logic              s_rready,
    output logic              s_awvalid,
    output logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awready,
    output logic              s_wvalid,
    output logic [DATA_W-1:0] s_wdata,
    output logic [STRB_W-1:0] s_wstrb,
    input  logic              s_wready,
    input  logic              s_bvalid,
    input  logic [1:0]        s_bresp,
    output logic              s_bready,
    output logic [1:0]        grant
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
    } state_t;

    state_t state, next_state;
    // owner / last_grant: 0 = m0 (IFU), 1 = m1 (LSU)
    logic   owner, next_owner;
    logic   last_grant, next_last_grant;
    logic   aw_done, next_aw_done;
    logic   w_done, next_w_done;

    // State register; last_grant resets to m1 so m0 wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            state      <= next_state;
            owner      <= next_owner;
            last_grant <= next_last_grant;
            aw_done    <= next_aw_done;
            w_done     <= next_w_done;
        end
    end

    // Next-state logic: round-robin arbitration in IDLE, handshake tracking elsewhere
    always_comb begin
        next_state      = state;
        next_owner      = owner;
        next_last_grant = last_grant;
        next_aw_done    = aw_done;
        next_w_done     = w_done;
        unique case (state)
            IDLE: begin
                if (m0_arvalid && (!(m1_awvalid || m1_arvalid) || last_grant)) begin
                    next_owner = 1'b0;
                    next_state = RD_ADDR;
                end else if (m1_awvalid || m1_arvalid) begin
                    next_owner = 1'b1;
                    next_state = m1_awvalid ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (s_arvalid && s_arready) begin
                    next_state = RD_DATA;
                end
            end
            RD_DATA: begin
                if (s_rvalid && s_rready) begin
                    next_state      = IDLE;
                    next_last_grant = owner;
                end
            end
            WR_REQ: begin
                next_aw_done = aw_done || (s_awvalid && s_awready);
                next_w_done  = w_done || (s_wvalid && s_wready);
                if (next_aw_done && next_w_done) begin
                    next_state = WR_RESP;
                end
            end
            WR_RESP: begin
                if (s_bvalid && s_bready) begin
                    next_state      = IDLE;
                    next_last_grant = 1'b1;
                    next_aw_done    = 1'b0;
                    next_w_done     = 1'b0;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Channel routing decoded from the registered state; everything idles at zero
    always_comb begin
        m0_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = 2'b00;
        m1_arready = 1'b0;
        m1_rvalid  = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = 2'b00;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bvalid  = 1'b0;
        m1_bresp   = 2'b00;
        s_arvalid  = 1'b0;
        s_araddr   = '0;
        s_rready   = 1'b0;
        s_awvalid  = 1'b0;
        s_awaddr   = '0;
        s_wvalid   = 1'b0;
        s_wdata    = '0;
        s_wstrb    = '0;
        s_bready   = 1'b0;
        grant      = 2'b00;
        if (state != IDLE) begin
            grant = owner ? 2'b10 : 2'b01;
        end
        unique case (state)
            RD_ADDR: begin
                s_arvalid = owner ? m1_arvalid : m0_arvalid;
                s_araddr  = owner ? m1_araddr : m0_araddr;
                if (owner) begin
                    m1_arready = s_arready;
                end else begin
                    m0_arready = s_arready;
                end
            end
            RD_DATA: begin
                s_rready = owner ? m1_rready : m0_rready;
                if (owner) begin
                    m1_rvalid = s_rvalid;
                    m1_rdata  = s_rdata;
                    m1_rresp  = s_rresp;
                end else begin
                    m0_rvalid = s_rvalid;
                    m0_rdata  = s_rdata;
                    m0_rresp  = s_rresp;
                end
            end
            WR_REQ: begin
                s_awvalid  = m1_awvalid && !aw_done;
                s_awaddr   = m1_awaddr;
                s_wvalid   = m1_wvalid && !w_done;
                s_wdata    = m1_wdata;
                s_wstrb    = m1_wstrb;
                m1_awready = s_awready && !aw_done;
                m1_wready  = s_wready && !w_done;
            end
            WR_RESP: begin
                s_bready  = m1_bready;
                m1_bvalid = s_bvalid;
                m1_bresp  = s_bresp;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: the bench plays both masters and the
// slave, queues expected responses when it drives the slave side and
// compares them when a master-side response handshake occurs.
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic [ADDR_W-1:0] m0_araddr;
    logic [DATA_W-1:0] m0_rdata;
    logic [1:0]        m0_rresp;
    logic              m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic [ADDR_W-1:0] m1_araddr, m1_awaddr;
    logic [DATA_W-1:0] m1_rdata, m1_wdata;
    logic [1:0]        m1_rresp, m1_bresp;
    logic              m1_awvalid, m1_awready, m1_wvalid, m1_wready;
    logic [STRB_W-1:0] m1_wstrb;
    logic              m1_bvalid, m1_bready;
    logic              s_arvalid, s_arready, s_rvalid, s_rready;
    logic [ADDR_W-1:0] s_araddr, s_awaddr;
    logic [DATA_W-1:0] s_rdata, s_wdata;
    logic [1:0]        s_rresp, s_bresp;
    logic              s_awvalid, s_awready, s_wvalid, s_wready;
    logic [STRB_W-1:0] s_wstrb;
    logic              s_bvalid, s_bready;
    logic [1:0]        grant;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) dut (
        .clk(clk), .rst(rst),
        .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arready(m0_arready),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rready(m0_rready),
        .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arready(m1_arready),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rready(m1_rready),
        .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awready(m1_awready),
        .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wready(m1_wready),
        .m1_bvalid(m1_bvalid), .m1_bresp(m1_bresp), .m1_bready(m1_bready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
        .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp), .s_bready(s_bready),
        .grant(grant)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int errorCount = 0;

    // kind: 0 = m0 read, 1 = m1 read, 2 = m1 write response
    typedef struct {
        int          kind;
        logic [31:0] data;
        logic [1:0]  resp;
    } sbEntry_t;

    sbEntry_t expQ[$];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic popCompare(input int kind, input logic [31:0] data, input logic [1:0] resp);
        sbEntry_t e;
        checkOutput("sb_nonempty", 32'(expQ.size() != 0), 32'd1);
        if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput("sb_kind", kind, e.kind);
            checkOutput("sb_data", data, e.data);
            checkOutput("sb_resp", resp, e.resp);
        end
    endtask

    // Response monitor: every master-side response handshake consumes one expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (m0_rvalid && m0_rready) popCompare(0, m0_rdata, m0_rresp);
            if (m1_rvalid && m1_rready) popCompare(1, m1_rdata, m1_rresp);
            if (m1_bvalid && m1_bready) popCompare(2, 32'd0, m1_bresp);
        end
    end

    task automatic applyStimulus(input logic m0Req, input logic [31:0] m0Addr,
                                 input logic m1Req, input logic [31:0] m1Addr);
        m0_arvalid = m0Req;
        m0_araddr  = m0Addr;
        m1_arvalid = m1Req;
        m1_araddr  = m1Addr;
    endtask

    task automatic waitGrant(input logic [1:0] want);
        int n = 0;
        while (grant == 2'b00 && n < 10) begin
            tick();
            n++;
        end
        checkOutput("grant", grant, want);
    endtask

    task automatic runRead(input int who, input logic [31:0] addr, input int arDelay,
                           input logic [31:0] data, input logic [1:0] resp);
        logic [1:0] want;
        want = (who != 0) ? 2'b10 : 2'b01;
        waitGrant(want);
        #1;
        checkOutput("s_arvalid", s_arvalid, 1);
        checkOutput("s_araddr", s_araddr, addr);
        for (int i = 0; i < arDelay; i++) begin
            checkOutput("arready_wait", (who != 0) ? m1_arready : m0_arready, 0);
            tick();
        end
        s_arready = 1'b1;
        #1;
        checkOutput("owner_arready", (who != 0) ? m1_arready : m0_arready, 1);
        checkOutput("other_arready", (who != 0) ? m0_arready : m1_arready, 0);
        tick();
        s_arready = 1'b0;
        if (who != 0) m1_arvalid = 1'b0;
        else m0_arvalid = 1'b0;
        s_rvalid = 1'b1;
        s_rdata  = data;
        s_rresp  = resp;
        expQ.push_back('{kind: who, data: data, resp: resp});
        #1;
        checkOutput("other_rvalid", (who != 0) ? m0_rvalid : m1_rvalid, 0);
        checkOutput("other_rdata", (who != 0) ? m0_rdata : m1_rdata, 0);
        checkOutput("s_rready", s_rready, 1);
        tick();
        s_rvalid = 1'b0;
        s_rdata  = '0;
        s_rresp  = 2'b00;
        #1;
        checkOutput("grant_idle_rd", grant, 0);
    endtask

    task automatic runWrite(input logic [31:0] addr, input logic [31:0] data, input logic [7:0] strb,
                            input int awDelay, input int wDelay, input logic [1:0] bresp);
        int last;
        last = (awDelay > wDelay) ? awDelay : wDelay;
        waitGrant(2'b10);
        #1;
        checkOutput("s_awaddr", s_awaddr, addr);
        checkOutput("s_wdata", s_wdata, data);
        checkOutput("s_wstrb", s_wstrb, strb);
        checkOutput("s_arvalid_wr", s_arvalid, 0);
        for (int c = 0; c <= last; c++) begin
            s_awready = (c >= awDelay);
            s_wready  = (c >= wDelay);
            #1;
            checkOutput("s_awvalid", s_awvalid, (c <= awDelay));
            checkOutput("s_wvalid", s_wvalid, (c <= wDelay));
            checkOutput("m1_awready", m1_awready, (c == awDelay));
            checkOutput("m1_wready", m1_wready, (c == wDelay));
            checkOutput("s_bready_wreq", s_bready, 0);
            tick();
        end
        m1_awvalid = 1'b0;
        m1_wvalid  = 1'b0;
        s_awready  = 1'b0;
        s_wready   = 1'b0;
        #1;
        checkOutput("grant_wresp", grant, 2'b10);
        checkOutput("s_bready_wresp", s_bready, 1);
        checkOutput("m1_bvalid_wait", m1_bvalid, 0);
        checkOutput("s_awvalid_wresp", s_awvalid, 0);
        tick();
        s_bvalid = 1'b1;
        s_bresp  = bresp;
        expQ.push_back('{kind: 2, data: 32'd0, resp: bresp});
        tick();
        s_bvalid = 1'b0;
        s_bresp  = 2'b00;
        #1;
        checkOutput("grant_idle_wr", grant, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        m0_arvalid = 0; m0_araddr = '0; m0_rready = 1;
        m1_arvalid = 0; m1_araddr = '0; m1_rready = 1;
        m1_awvalid = 0; m1_awaddr = '0; m1_wvalid = 0; m1_wdata = '0; m1_wstrb = '0;
        m1_bready = 1;
        s_arready = 0; s_rvalid = 0; s_rdata = '0; s_rresp = 0;
        s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0;
        rst = 1'b1;
        tick();
        tick();
        checkOutput("rst_grant", grant, 0);
        checkOutput("rst_s_arvalid", s_arvalid, 0);
        checkOutput("rst_s_awvalid", s_awvalid, 0);
        checkOutput("rst_s_rready", s_rready, 0);
        checkOutput("rst_s_bready", s_bready, 0);
        checkOutput("rst_s_araddr", s_araddr, 0);
        rst = 1'b0;

        // m0 read alone with a slow slave address accept
        applyStimulus(1, 32'h8000_0000, 0, 0);
        #1;
        checkOutput("idle_m0_arready", m0_arready, 0);
        checkOutput("idle_grant", grant, 0);
        runRead(0, 32'h8000_0000, 3, 32'h0000_0413, 2'b00);

        // last grant was m0, so a simultaneous pair now goes to m1 first
        applyStimulus(1, 32'h8000_0010, 1, 32'h9000_0020);
        runRead(1, 32'h9000_0020, 0, 32'h1111_1111, 2'b00);
        runRead(0, 32'h8000_0010, 1, 32'h2222_2222, 2'b00);

        // after reset m0 wins the first tie
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(1, 32'h8000_0020, 1, 32'h9000_0030);
        runRead(0, 32'h8000_0020, 0, 32'h3333_3333, 2'b00);
        runRead(1, 32'h9000_0030, 2, 32'h4444_4444, 2'b01);

        // write with AW accepted two cycles before W
        m1_awvalid = 1; m1_awaddr = 32'ha000_03f8;
        m1_wvalid = 1; m1_wdata = 32'h0000_0041; m1_wstrb = 8'h01;
        runWrite(32'ha000_03f8, 32'h0000_0041, 8'h01, 0, 2, 2'b00);

        // m1 write and read together: write first, AW/W in the same cycle
        m1_awvalid = 1; m1_awaddr = 32'ha000_0100;
        m1_wvalid = 1; m1_wdata = 32'hdead_beef; m1_wstrb = 8'hff;
        m1_arvalid = 1; m1_araddr = 32'h9000_0040;
        runWrite(32'ha000_0100, 32'hdead_beef, 8'hff, 1, 1, 2'b10);
        runRead(1, 32'h9000_0040, 0, 32'h0000_0033, 2'b00);

        // m1 read request arriving while m0 owns the slave stays isolated
        applyStimulus(1, 32'h8000_0050, 0, 0);
        tick();
        m1_arvalid = 1; m1_araddr = 32'h9000_0060;
        runRead(0, 32'h8000_0050, 1, 32'h0000_0044, 2'b00);
        runRead(1, 32'h9000_0060, 0, 32'h0000_0055, 2'b00);

        // reset in RD_DATA abandons the read
        applyStimulus(1, 32'h8000_0070, 0, 0);
        tick();
        s_arready = 1;
        tick();
        s_arready = 0;
        m0_arvalid = 0;
        #1;
        checkOutput("rd_data_grant", grant, 2'b01);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checkOutput("midrst_grant", grant, 0);
        checkOutput("midrst_s_rready", s_rready, 0);
        checkOutput("midrst_m0_rvalid", m0_rvalid, 0);
        checkOutput("midrst_s_arvalid", s_arvalid, 0);
        applyStimulus(1, 32'h8000_0004, 0, 0);
        runRead(0, 32'h8000_0004, 0, 32'h0000_0066, 2'b10);

        tick();
        checkOutput("sb_empty", expQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master, one-slave AXI-lite arbiter sharing the single memory port between instruction fetch and the load/store path.
- m0 is the IFU and is read-only (AR/R channels only).
- m1 is the load/store unit and uses the full AR/R/AW/W/B channel set.
- At most one transaction is in flight on the slave side. The owner is locked from address handshake through response handshake.

Parameters:
ADDR_W  32  address width on all channels
DATA_W  32  read/write data width
STRB_W  8   write strobe width (matches load/store unit mem_wstrb)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
m0_arvalid / m0_araddr  in  1 / ADDR_W  IFU read address request
m0_arready  out  1  IFU read address accepted
m0_rvalid / m0_rdata / m0_rresp  out  1 / DATA_W / 2  IFU read response
m0_rready  in  1  IFU ready for response
m1_arvalid / m1_araddr  in  1 / ADDR_W  LSU read address request
m1_arready  out  1  LSU read address accepted
m1_rvalid / m1_rdata / m1_rresp  out  1 / DATA_W / 2  LSU read response
m1_rready  in  1  LSU ready for read response
m1_awvalid / m1_awaddr  in  1 / ADDR_W  LSU write address
m1_awready  out  1  write address accepted
m1_wvalid / m1_wdata / m1_wstrb  in  1 / DATA_W / STRB_W  LSU write data
m1_wready  out  1  write data accepted
m1_bvalid / m1_bresp  out  1 / 2  LSU write response
m1_bready  in  1  LSU ready for write response
s_arvalid / s_araddr  out  1 / ADDR_W  slave read address
s_arready  in  1  slave read address accepted
s_rvalid / s_rdata / s_rresp  in  1 / DATA_W / 2  slave read response
s_rready  out  1  to slave
s_awvalid / s_awaddr  out  1 / ADDR_W  slave write address
s_awready  in  1  slave write address accepted
s_wvalid / s_wdata / s_wstrb  out  1 / DATA_W / STRB_W  slave write data
s_wready  in  1  slave write data accepted
s_bvalid / s_bresp  in  1 / 2  slave write response
s_bready  out  1  to slave
grant  out  2  one-hot current owner: bit0 = m0, bit1 = m1; 0 when idle

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP. Registered signals: owner, last_grant, aw_done, w_done.
- All outputs are combinational decodes of registered state. There is no valid-to-ready path while in IDLE.
- Reset values:
  - state=IDLE, last_grant=m1 (so m0 wins the first tie), aw_done=w_done=0.
  - Every output is 0 in IDLE, including s_*addr, s_wdata, s_wstrb and m*_rdata.
- IDLE arbitration, evaluated each cycle:
  - Requests: m0 = m0_arvalid; m1 = m1_awvalid | m1_arvalid.
  - If both request, the master that is not last_grant wins (round-robin).
  - Within m1, awvalid takes priority over arvalid.
  - Winner of a read goes to RD_ADDR; an m1 write goes to WR_REQ.
  - Grant takes effect on the next edge, so there is a one-cycle arbitration latency and no handshake occurs in the IDLE cycle.
- RD_ADDR:
  - s_arvalid/s_araddr are routed from the owner; the owner's arready = s_arready.
  - On s_arvalid & s_arready, go to RD_DATA.
- RD_DATA:
  - s_rready = owner rready; owner rvalid/rdata/rresp = slave values.
  - On s_rvalid & s_rready, go to IDLE and set last_grant = owner.
- WR_REQ (owner m1):
  - s_awvalid = m1_awvalid & ~aw_done; s_wvalid = m1_wvalid & ~w_done.
  - m1_awready and m1_wready mirror slave readies, gated the same way.
  - An AW handshake sets aw_done; a W handshake sets w_done.
  - Go to WR_RESP when both are done. This includes both handshaking in the same cycle, and one already done plus the other handshaking now.
- WR_RESP:
  - Route B to m1; s_bready = m1_bready.
  - On s_bvalid & s_bready, go to IDLE, set last_grant = m1, clear aw_done and w_done.
- Isolation: the non-owner sees arready/rvalid/awready/wready/bvalid = 0 and rdata = 0, regardless of slave activity.
- Responses: rresp and bresp pass through unmodified. Error responses end the transaction normally, with no retry.
- Request stability: requests that deassert before handshake are honoured as-is. The block does not buffer requests.
- Reset mid-transaction: the transaction is abandoned and the state returns to IDLE on that edge. The slave is expected to be reset by the same rst.

Test Plan:
- m0 read 0x80000000 alone; s_arready after 3 cycles; s_rdata 0x00000413, rresp 0 -> m0_rvalid with rdata 0x00000413 for one handshake cycle; grant 01 then 00; m1 outputs all 0 throughout.
- After reset, m0_arvalid and m1_arvalid asserted in the same cycle -> m0 served first, then m1. A second simultaneous pair -> m1 served first.
- m1 write awaddr 0xa00003f8, wdata 0x41, wstrb 0x01; s_awready in cycle N, s_wready in cycle N+2 -> s_awvalid drops after N, state stays WR_REQ until N+2, then WR_RESP. s_bvalid with bresp 0 -> m1_bvalid; return to IDLE.
- m1_awvalid and m1_arvalid both high in IDLE -> write completes fully before the read is issued. AW and W handshaking in the same cycle -> WR_RESP on the next edge.
- m1_arvalid held while m0 is in RD_DATA and slave pulses s_rvalid -> m1_rvalid stays 0 and m1_arready stays 0 until m0 completes.
- rst asserted in RD_DATA -> all outputs 0 on the next cycle; a following m0 read at 0x80000004 completes normally; s_rresp=2 returned -> m0_rresp=2 and state returns to IDLE.
